// File: rtl/pe_rx_checker_pkg.sv
// Shared constants for the PE receive checker: flit field offsets, FSM states and the LFSR.
package pe_rx_checker_pkg;

    localparam logic [15:0] LFSR_SEED_BASE = 16'hACE1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } rx_state_e;

    // One step of the 16-bit maximal LFSR (taps 16,14,13,11), right-shifting form.
    function automatic logic [15:0] lfsr16_next(input logic [15:0] q);
        return {q[0] ^ q[2] ^ q[3] ^ q[5], q[15:1]};
    endfunction

    // Flit layout: dest x, dest y, then payload = src x, src y, seq.
    function automatic int unsigned dest_y_lsb(input int unsigned xs);
        return xs;
    endfunction

    function automatic int unsigned src_x_lsb(input int unsigned xs, input int unsigned ys);
        return xs + ys;
    endfunction

    function automatic int unsigned src_y_lsb(input int unsigned xs, input int unsigned ys);
        return 2 * xs + ys;
    endfunction

    function automatic int unsigned seq_lsb(input int unsigned xs, input int unsigned ys);
        return 2 * xs + 2 * ys;
    endfunction

endpackage

// File: rtl/pe_lfsr16.sv
// 16-bit free-running LFSR, loaded with seed on reset; shared with the traffic generator.
module pe_lfsr16
    import pe_rx_checker_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic [15:0] seed,
    output logic [15:0] out
);

    logic [15:0] lfsr_q;

    // Advance once per cycle whenever out of reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lfsr_q <= seed;
        end else begin
            lfsr_q <= lfsr16_next(lfsr_q);
        end
    end

    assign out = lfsr_q;

endmodule

// File: rtl/pe_rx_checker.sv
// Receive-side checker for a mesh PE: accepts flits, verifies routing and per-source sequencing.
module pe_rx_checker
    import pe_rx_checker_pkg::*;
#(
    parameter int unsigned xcord         = 0,
    parameter int unsigned ycord         = 0,
    parameter int unsigned X             = 2,
    parameter int unsigned Y             = 2,
    parameter int unsigned x_size        = 1,
    parameter int unsigned y_size        = 1,
    parameter int unsigned data_width    = 256,
    parameter int unsigned total_width   = x_size + y_size + data_width,
    parameter int unsigned seq_width     = 16,
    parameter int unsigned expected_pkts = 100,
    parameter int unsigned throttle      = 0
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic                   i_valid,
    input  logic [total_width-1:0] i_data,
    output logic                   o_ready,
    output logic                   done,
    output logic                   err,
    output logic [31:0]            rx_count,
    output logic [15:0]            err_count
);

    localparam int unsigned DEST_Y_LSB = dest_y_lsb(x_size);
    localparam int unsigned SRC_X_LSB  = src_x_lsb(x_size, y_size);
    localparam int unsigned SRC_Y_LSB  = src_y_lsb(x_size, y_size);
    localparam int unsigned SEQ_LSB    = seq_lsb(x_size, y_size);
    localparam int unsigned FIELDS_END = SEQ_LSB + seq_width;
    localparam int unsigned N_SRC      = X * Y;
    localparam int unsigned IDX_W      = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam logic [15:0] LFSR_SEED  = 16'(32'(LFSR_SEED_BASE) + xcord + X * ycord);

    rx_state_e             state_q, state_d;
    logic                  ready_q, ready_d;
    logic                  done_q;
    logic                  err_q, err_d;
    logic [31:0]           rx_count_q, rx_count_d;
    logic [15:0]           err_count_q, err_count_d;

    logic [seq_width-1:0]  tbl_seq_q [N_SRC];
    logic [N_SRC-1:0]      tbl_vld_q;

    logic [15:0]           lfsr_out;
    logic [15:0]           lfsr_next;

    logic [x_size-1:0]     dest_x, src_x;
    logic [y_size-1:0]     dest_y, src_y;
    logic [seq_width-1:0]  seq;
    logic [IDX_W-1:0]      src_idx;
    logic                  xfer;
    logic                  src_in_range;
    logic                  bad_dest;
    logic                  self_src;
    logic                  stale_seq;
    logic                  overrun;
    logic                  flit_err;

    pe_lfsr16 u_lfsr (
        .clk  (clk),
        .rstn (rstn),
        .seed (LFSR_SEED),
        .out  (lfsr_out)
    );

    assign lfsr_next = lfsr16_next(lfsr_out);

    assign dest_x = i_data[0 +: x_size];
    assign dest_y = i_data[DEST_Y_LSB +: y_size];
    assign src_x  = i_data[SRC_X_LSB +: x_size];
    assign src_y  = i_data[SRC_Y_LSB +: y_size];
    assign seq    = i_data[SEQ_LSB +: seq_width];

    // Payload bits above the checked fields carry no information for this block.
    if (total_width > FIELDS_END) begin : g_unused_payload
        logic unused_payload;
        assign unused_payload = ^i_data[total_width-1:FIELDS_END];
    end

    // Per-flit checks; evaluated every cycle, only acted on when a transfer occurs.
    always_comb begin
        xfer         = i_valid & ready_q;
        src_in_range = (32'(src_x) < X) && (32'(src_y) < Y);
        src_idx      = IDX_W'(32'(src_x) + X * 32'(src_y));
        bad_dest     = (32'(dest_x) != xcord) || (32'(dest_y) != ycord);
        self_src     = (32'(src_x) == xcord) && (32'(src_y) == ycord);
        stale_seq    = src_in_range && tbl_vld_q[src_idx] && (seq <= tbl_seq_q[src_idx]);
        overrun      = (state_q == ST_DONE);
        flit_err     = bad_dest | self_src | ~src_in_range | stale_seq | overrun;
    end

    // Next-state values for counters, sticky error, FSM and ready.
    always_comb begin
        rx_count_d  = rx_count_q;
        err_count_d = err_count_q;
        err_d       = err_q;
        state_d     = state_q;
        ready_d     = 1'b0;

        if (xfer && (rx_count_q != 32'hFFFF_FFFF)) begin
            rx_count_d = rx_count_q + 32'd1;
        end
        if (xfer && flit_err) begin
            err_d = 1'b1;
            if (err_count_q != 16'hFFFF) begin
                err_count_d = err_count_q + 16'd1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (expected_pkts == 0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (rx_count_d >= 32'(expected_pkts)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase

        // Ready is registered so it follows the LFSR value it will sit beside next cycle.
        case (state_d)
            ST_RUN:  ready_d = (throttle != 0) ? lfsr_next[0] : 1'b1;
            ST_DONE: ready_d = 1'b1;
            default: ready_d = 1'b0;
        endcase
    end

    // FSM state and registered status outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rx_count_q  <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            done_q      <= (state_d == ST_DONE);
            err_q       <= err_d;
            rx_count_q  <= rx_count_d;
            err_count_q <= err_count_d;
        end
    end

    // Last-seen seq per source; updated for any in-range source even on a failed check.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(N_SRC); i++) begin
                tbl_seq_q[i] <= '0;
            end
            tbl_vld_q <= '0;
        end else if (xfer && src_in_range) begin
            tbl_seq_q[src_idx] <= seq;
            tbl_vld_q[src_idx] <= 1'b1;
        end
    end

    assign o_ready   = ready_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rx_count  = rx_count_q;
    assign err_count = err_count_q;

endmodule

// File: doc/pe_rx_checker.md
PE_RX_CHECKER -- requirements
Module: pe_rx_checker

Interface
REQ-001 Parameters SHALL be: xcord 0 (own X coordinate); ycord 0 (own Y coordinate); X 2 (mesh columns); Y 2 (mesh rows); x_size 1; y_size 1; data_width 256; total_width x_size+y_size+data_width; seq_width 16; expected_pkts 100 (packets to receive before done); throttle 0 (0 = always ready, 1 = LFSR-throttled ready).
REQ-002 Clock and reset SHALL be: clk in 1 (single clock, all logic rising edge); rstn in 1 (asynchronous, active-low reset).
REQ-003 Control ports SHALL be: start in 1 (begin receiving; level or pulse).
REQ-004 Data ports SHALL be: i_valid in 1 (flit from router local port valid); i_data in total_width (flit); o_ready out 1 (checker can accept).
REQ-005 Status ports SHALL be: done out 1; err out 1 (sticky); rx_count out 32; err_count out 16.

Function
REQ-006 Flit layout SHALL be:
- dest x = i_data[x_size-1:0]
- dest y = next y_size bits
- payload starts at bit x_size+y_size: src x (x_size), then src y (y_size), then seq (seq_width).
REQ-007 A transfer SHALL occur on a rising clk edge with i_valid=1 and o_ready=1; no other cycle consumes a flit.
REQ-008 FSM SHALL have three states:
- IDLE: o_ready=0; go to RUN on start=1.
- RUN: accept flits; go to DONE the cycle rx_count reaches expected_pkts.
- DONE: done=1; o_ready=1 permanently, so late traffic drains and is flagged.
REQ-009 rx_count SHALL increment by 1 per transfer, saturating at 2^32-1.
REQ-010 Per-source last-seq table SHALL hold X*Y entries of seq_width bits plus a valid bit, indexed src x + X*src y; all entries SHALL be invalid after reset.
REQ-011 Each transfer SHALL be checked. Any of the following is an error:
- dest != (xcord, ycord)
- src == own coordinates
- src x >= X or src y >= Y
- table entry valid and seq <= stored seq (unsigned, no wrap)
- transfer accepted while in DONE (overrun).
REQ-012 On an in-range source the table entry SHALL be updated with seq and marked valid, even when another check failed.
REQ-013 The error result SHALL be registered: err sets, and err_count increments by 1 (saturating at 2^16-1), exactly one cycle after the erroneous transfer. One erroneous transfer SHALL count once, whatever the number of failed checks.
REQ-014 With throttle=0, o_ready SHALL be 1 in RUN and DONE. With throttle=1, o_ready in RUN SHALL equal LFSR bit 0.
- LFSR: 16-bit maximal (taps 16,14,13,11), seed 16'hACE1 + xcord + X*ycord.
- Advances every cycle outside reset.
REQ-015 o_ready SHALL depend only on registered state, never combinationally on i_valid.
REQ-016 start asserted outside IDLE SHALL be ignored.
REQ-017 With expected_pkts=0, the FSM SHALL go IDLE -> DONE on start.

Reset
REQ-018 On rstn=0 the block SHALL asynchronously clear to: state IDLE, o_ready=0, done=0, err=0, rx_count=0, err_count=0, table invalid, LFSR at seed.
REQ-019 Reset mid-packet-stream SHALL discard all history; the first flit after reset and start SHALL NOT be checked against pre-reset seq values.
REQ-020 Reset deassertion SHALL be synchronised by the enclosing bench; the block SHALL contain no reset synchroniser.

Structure
REQ-021 Flit field offsets and the LFSR tap/seed constants SHALL live in the shared include file used by the mesh and PE models.
REQ-022 The LFSR SHALL be one sub-module, pe_lfsr16 (ports clk, rstn, seed, out), reused by the traffic generator.
REQ-023 The table SHALL be a register array, not inferred RAM, so that it is reset asynchronously.

Verification
REQ-024 xcord=1, ycord=0, X=Y=2, expected_pkts=3, throttle=0: start, then three flits from src (0,0) with seq 1,2,3 -> rx_count=3, done=1 the cycle after the third transfer, err=0.
REQ-025 Flit with dest (0,1) to checker at (1,0) -> err=1 and err_count=1 one cycle later; rx_count increments.
REQ-026 From src (1,1): seq 5 then seq 5 -> second flit flagged, err_count=1. Then seq 6 -> no new error.
REQ-027 expected_pkts=2: send 3 valid flits -> done after the 2nd; the 3rd is accepted as overrun, err_count=1, rx_count=3.
REQ-028 throttle=1, i_valid held 1 for 1000 cycles -> transfers occur only where o_ready=1, rx_count equals the number of o_ready=1 cycles in RUN, and o_ready=0 for the whole of IDLE.
REQ-029 Assert rstn=0 mid-stream after seq 10 from (0,0), then restart and send seq 1 from (0,0) -> no error, rx_count=1.
